// File: rtl/axi_cmd_pkg.sv
// Shared definitions for the AXI-Stream command framer (tx) and its matching rx decoder.
package axi_cmd_pkg;

  localparam logic [31:0] WRITE_CMD      = 32'h5757_5757;
  localparam int          GAP_CYCLES_DEF = 24;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_CMD  = 3'd1,
    HDR_MARK = 3'd2,
    HDR_ID   = 3'd3,
    DATA     = 3'd4,
    GAP      = 3'd5
  } cmd_state_e;

  // Frame IDs are never zero: all-ones wraps straight to 1.
  function automatic logic [31:0] next_id(input logic [31:0] id);
    return (id == 32'hFFFF_FFFF) ? 32'd1 : id + 32'd1;
  endfunction

endpackage

// File: rtl/axi_tx_command_gen.sv
// Frames a payload stream as {cmd_word, WRITE_CMD, id, payload...} on a registered
// AXI-Stream output, then holds tvalid low for GAP_CYCLES before the next frame.
module axi_tx_command_gen
  import axi_cmd_pkg::*;
#(
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int ID_WIDTH   = 32
) (
  input  logic                axi_tclk,
  input  logic                axi_treset,
  input  logic                enable_tx_encode,
  input  logic [31:0]         cmd_word,
  input  logic [31:0]         data_axis_tdata,
  input  logic                data_axis_tvalid,
  input  logic                data_axis_tlast,
  output logic                data_axis_tready,
  output logic [31:0]         tdata,
  output logic                tvalid,
  output logic                tlast,
  input  logic                tready,
  output logic [ID_WIDTH-1:0] cmd_id,
  output logic                cmd_err
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  cmd_state_e          state_q;
  logic [31:0]         tdata_q;
  logic                tvalid_q;
  logic                tlast_q;
  logic [31:0]         cmd_hdr_q;
  logic [ID_WIDTH-1:0] id_cnt_q;
  logic [ID_WIDTH-1:0] cmd_id_q;
  logic                cmd_err_q;
  logic [GW-1:0]       gap_cnt_q;
  logic                can_load;

  // Output register is free when empty or being drained this cycle.
  assign can_load         = !tvalid_q || tready;
  assign data_axis_tready = (state_q == DATA) && can_load;

  assign tdata   = tdata_q;
  assign tvalid  = tvalid_q;
  assign tlast   = tlast_q;
  assign cmd_id  = cmd_id_q;
  assign cmd_err = cmd_err_q;

  always_ff @(posedge axi_tclk) begin
    if (axi_treset) begin
      state_q   <= IDLE;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      cmd_hdr_q <= '0;
      id_cnt_q  <= '0;
      cmd_id_q  <= '0;
      cmd_err_q <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      cmd_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_tx_encode && data_axis_tvalid && can_load) begin
            state_q   <= HDR_CMD;
            cmd_hdr_q <= (cmd_word == WRITE_CMD) ? 32'h0 : cmd_word;
            cmd_err_q <= (cmd_word == WRITE_CMD);
            id_cnt_q  <= next_id(id_cnt_q);
            cmd_id_q  <= next_id(id_cnt_q);
          end
        end
        HDR_CMD: begin
          if (can_load) begin
            tdata_q  <= cmd_hdr_q;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            state_q  <= HDR_MARK;
          end
        end
        HDR_MARK: begin
          if (can_load) begin
            tdata_q <= WRITE_CMD;
            state_q <= HDR_ID;
          end
        end
        HDR_ID: begin
          if (can_load) begin
            tdata_q <= id_cnt_q;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (can_load) begin
            tvalid_q <= data_axis_tvalid;
            tlast_q  <= 1'b0;
            if (data_axis_tvalid) begin
              tdata_q <= data_axis_tdata;
              tlast_q <= data_axis_tlast;
              if (data_axis_tlast) begin
                state_q   <= GAP;
                gap_cnt_q <= '0;
              end
            end
          end
        end
        GAP: begin
          // The gap only starts counting once the tlast word has left.
          if (tvalid_q) begin
            if (tready) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
            end
          end else if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_tx_command_gen.md
AXI_TX_COMMAND_GEN -- requirements
Module: axi_tx_command_gen

Interface
REQ-001 Parameter GAP_CYCLES, default 24, meaning idle cycles with tvalid low after each frame's last word.
REQ-002 Parameter ID_WIDTH, default 32, meaning command ID width; fixed at 32 in this revision.
REQ-003 Port axi_tclk  input  1  sole clock; all logic on rising edge.
REQ-004 Port axi_treset  input  1  synchronous, active-high reset.
REQ-005 Port enable_tx_encode  input  1  permits starting a new frame.
REQ-006 Port cmd_word  input  32  command word, sampled at frame start.
REQ-007 Port data_axis_tdata  input  32  payload word.
REQ-008 Port data_axis_tvalid  input  1  payload valid.
REQ-009 Port data_axis_tlast  input  1  last payload word of a frame.
REQ-010 Port data_axis_tready  output  1  payload accepted when high with tvalid.
REQ-011 Port tdata  output  32  framed output word, registered.
REQ-012 Port tvalid  output  1  framed output valid, registered.
REQ-013 Port tlast  output  1  marks the final payload word of a frame, registered.
REQ-014 Port tready  input  1  downstream ready.
REQ-015 Port cmd_id  output  32  ID used by the most recent frame.
REQ-016 Port cmd_err  output  1  one-cycle pulse: cmd_word equalled WRITE_CMD.

Function
REQ-017 Frame on tdata SHALL be: cmd_word, WRITE_CMD (0x57575757), cmd ID, then payload words in order; tlast high only on the payload word that carried data_axis_tlast.
REQ-018 States SHALL be IDLE, HDR_CMD, HDR_MARK, HDR_ID, DATA, GAP.
REQ-019 IDLE->HDR_CMD when enable_tx_encode & data_axis_tvalid & (!tvalid | tready); cmd_word is latched on that edge and the ID counter increments.
REQ-020 The output register SHALL load a new word only when !tvalid | tready; tdata/tvalid/tlast SHALL hold stable while tvalid & !tready.
REQ-021 Each header state SHALL load its word and advance in one cycle when the output register can load; the first header word appears on tdata one cycle after leaving IDLE.
REQ-022 data_axis_tready SHALL be high only in DATA and only when !tvalid | tready; each accepted beat loads into the output register with one-cycle latency.
REQ-023 DATA->GAP on the accepted beat with data_axis_tlast; a payload of one word is legal.
REQ-024 GAP SHALL count GAP_CYCLES cycles, starting after the tlast beat is taken by downstream, with tvalid low; it then returns to IDLE.
REQ-025 The ID counter SHALL increment per frame and never emit 0: 0xFFFFFFFF wraps to 0x00000001. The first frame after reset uses ID 1.
REQ-026 If the latched cmd_word equals WRITE_CMD, it SHALL be replaced by 0x00000000 in the frame and cmd_err SHALL pulse for one cycle; the frame still proceeds.
REQ-027 Payload words equal to WRITE_CMD SHALL pass unmodified.
REQ-028 Deasserting enable_tx_encode mid-frame SHALL NOT abort the frame; it only blocks the next IDLE exit.
REQ-029 cmd_id SHALL update on the IDLE->HDR_CMD edge.

Reset
REQ-030 On axi_treset, the block SHALL force state IDLE and clear tdata to 0, tvalid to 0, tlast to 0, data_axis_tready to 0, cmd_id to 0, cmd_err to 0, the ID counter to 0, and the gap counter to 0.
REQ-031 Reset mid-frame SHALL drop the partial frame, with no tlast emitted. The next frame uses ID 1.

Structure
REQ-032 A shared package axi_cmd_pkg SHALL hold WRITE_CMD, the state encodings, and the GAP_CYCLES default; the matching rx decoder also uses this package.
REQ-033 The design SHALL be a single module with no sub-modules; the output register and the FSM are in-line.

Verification
REQ-034 Stimulus: enable=1, cmd_word=0x00000012, payload 0xA0,0xA1,0xA2 (tlast on 0xA2), tready=1. Required output: 0x12, 0x57575757, 0x1, 0xA0, 0xA1, 0xA2 with tlast on 0xA2, then exactly 24 cycles of tvalid low.
REQ-035 Stimulus: same frame with tready toggling 1/0 every cycle. Required: identical word sequence, no drops or duplicates, and outputs held stable while stalled.
REQ-036 Stimulus: preload the ID counter to 0xFFFFFFFE, then send two frames. Required: IDs 0xFFFFFFFF then 0x00000001.
REQ-037 Stimulus: cmd_word=0x57575757. Required: first word 0x00000000 and a single cmd_err pulse. Stimulus: a payload word 0x57575757. Required: it passes through unchanged.
REQ-038 Stimulus: assert reset during DATA after 2 payload words. Required: tvalid=0 on the next cycle, no tlast, and the next frame carries ID 1.
REQ-039 Stimulus: loop the output into the rx decoder with two frames of distinct IDs. Required: both payloads are forwarded intact.
